// File: rtl/aes_inv_mix_column.sv
// ---------------------------------------------------------------------------
// aes_inv_mix_column
//
// AES InvMixColumns over one 32-bit state column. The GF(2^8) math is fully
// combinational. A single output register gives a fixed latency of one cycle.
// The block applies no backpressure, so it accepts one column every cycle.
//
// Ports
//   clk                in   rising-edge clock
//   rst_n              in   asynchronous, active-low reset
//   in_valid           in   inv_mixcolumn_in is valid this cycle
//   inv_mixcolumn_in   in   [31:24]=a0 [23:16]=a1 [15:8]=a2 [7:0]=a3
//   out_valid          out  one-cycle pulse aligned with its result
//   inv_mixcolumn_out  out  registered result, b0..b3 in the same byte order
//                           as the input; holds its value while idle
// ---------------------------------------------------------------------------
module aes_inv_mix_column (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] inv_mixcolumn_in,
  output logic        out_valid,
  output logic [31:0] inv_mixcolumn_out
);

  // Multiply by x (0x02) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // The four InvMixColumns coefficients, each built from the x2/x4/x8 chain.
  function automatic logic [7:0] mul_09(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x;
  endfunction

  function automatic logic [7:0] mul_0b(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ x;
  endfunction

  function automatic logic [7:0] mul_0d(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x;
  endfunction

  function automatic logic [7:0] mul_0e(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Split the input column into its four bytes.
  logic [7:0] a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;

  assign a0 = inv_mixcolumn_in[31:24];
  assign a1 = inv_mixcolumn_in[23:16];
  assign a2 = inv_mixcolumn_in[15:8];
  assign a3 = inv_mixcolumn_in[7:0];

  // Each output row applies the circulant matrix rotated by one position.
  assign b0 = mul_0e(a0) ^ mul_0b(a1) ^ mul_0d(a2) ^ mul_09(a3);
  assign b1 = mul_09(a0) ^ mul_0e(a1) ^ mul_0b(a2) ^ mul_0d(a3);
  assign b2 = mul_0d(a0) ^ mul_09(a1) ^ mul_0e(a2) ^ mul_0b(a3);
  assign b3 = mul_0b(a0) ^ mul_0d(a1) ^ mul_09(a2) ^ mul_0e(a3);

  // Output register.
  logic        valid_q, valid_d;
  logic [31:0] data_q,  data_d;

  always_comb begin
    // NOTE: every always_comb output is given a default first, so that no
    // path through the block leaves it unassigned and infers a latch.
    valid_d = 1'b0;
    data_d  = data_q;
    if (in_valid) begin
      valid_d = 1'b1;
      data_d  = {b0, b1, b2, b3};
    end
  end

  // NOTE: the reset is asynchronous, so both outputs clear as soon as rst_n
  // falls, without waiting for a clock edge. This also drops any result
  // still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= 32'h0000_0000;
    end else begin
      // NOTE: sequential state is written with non-blocking assignments only,
      // so every register samples pre-edge values with no race.
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid         = valid_q;
  assign inv_mixcolumn_out = data_q;

endmodule

// File: tb/tb_aes_inv_mix_column.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_mix_column
//
// Scoreboard bench. The driver changes inputs on the falling edge. When it
// issues a valid column, it pushes {input, expected} into a queue.
//
// The monitor samples 2 ns after every rising edge:
//   - queue not empty: out_valid must be 1, the head entry is popped and
//     compared, and the result is sent through a reference MixColumns that
//     must give back the original input.
//   - queue empty: out_valid must be 0, and the output must hold the last
//     result (0 after reset).
//
// The reference model is a generic GF(2^8) shift-and-add multiply, applied
// to the coefficient matrices row by row.
// ---------------------------------------------------------------------------
module tb_aes_inv_mix_column;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] inv_mixcolumn_in;
  logic        out_valid;
  logic [31:0] inv_mixcolumn_out;

  aes_inv_mix_column dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .inv_mixcolumn_in  (inv_mixcolumn_in),
    .out_valid         (out_valid),
    .inv_mixcolumn_out (inv_mixcolumn_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] din;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  logic [31:0] last_exp;
  int          tests_run;
  int          tests_failed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // GF(2^8) product by schoolbook shift-and-add, reduced by 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // Apply a circulant matrix, given by its first row, to a column.
  function automatic logic [31:0] circ_mul(input logic [31:0] col, input logic [31:0] row0);
    logic [7:0] a [4];
    logic [7:0] c [4];
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) begin
      a[i] = col[31 - 8*i -: 8];
      c[i] = row0[31 - 8*i -: 8];
    end
    for (int r = 0; r < 4; r++) begin
      b[r] = 8'h00;
      for (int k = 0; k < 4; k++)
        b[r] = b[r] ^ gf_mul(c[(k - r + 4) % 4], a[k]);
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic logic [31:0] ref_inv_mix(input logic [31:0] col);
    return circ_mul(col, 32'h0e0b0d09);
  endfunction

  function automatic logic [31:0] ref_mix(input logic [31:0] col);
    return circ_mul(col, 32'h02030101);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] e);
    @(negedge clk);
    in_valid         = v;
    inv_mixcolumn_in = d;
    if (v) sb_q.push_back('{din: d, exp: e});
  endtask

  task automatic drive_ref(input logic v, input logic [31:0] d);
    drive(v, d, ref_inv_mix(d));
  endtask

  // Idle cycle with garbage on the data input, which the DUT must ignore.
  task automatic idle();
    drive(1'b0, $urandom, 32'h0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() != 0) begin
        sb_entry_t e;
        e = sb_q.pop_front();
        check("out_valid_expected_high", {31'b0, out_valid}, 32'd1);
        check("result", inv_mixcolumn_out, e.exp);
        check("mixcolumns_roundtrip", ref_mix(inv_mixcolumn_out), e.din);
        last_exp = e.exp;
      end else begin
        check("out_valid_expected_low", {31'b0, out_valid}, 32'd0);
        check("hold_when_idle", inv_mixcolumn_out, last_exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] KAT_IN  [5] = '{32'h8e4da1bc, 32'h4d7ebdf8, 32'h9fdc589d,
                                          32'h00000000, 32'h01010101};
  localparam logic [31:0] KAT_OUT [5] = '{32'hdb135345, 32'h2d26314c, 32'hf20a225c,
                                          32'h00000000, 32'h01010101};

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    last_exp         = 32'h0;
    rst_n            = 1'b0;
    in_valid         = 1'b0;
    inv_mixcolumn_in = 32'h0;

    // Reset state, checked before any clock edge.
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_data", inv_mixcolumn_out, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Known answers and degenerate inputs, applied back to back.
    for (int i = 0; i < 5; i++) drive(1'b1, KAT_IN[i], KAT_OUT[i]);

    // A gap after one vector: out_valid drops and the output holds.
    idle();
    drive(1'b1, KAT_IN[0], KAT_OUT[0]);
    idle();
    idle();
    drive(1'b1, KAT_IN[2], KAT_OUT[2]);

    // Async reset between edges while out_valid is high.
    @(posedge clk);
    #3;
    check("pre_reset_out_valid", {31'b0, out_valid}, 32'd1);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    inv_mixcolumn_in = 32'hdeadbeef;
    sb_q.delete();
    last_exp = 32'h0;
    #1;
    check("async_reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_reset_out_data", inv_mixcolumn_out, 32'h0);
    // Valid input during reset must be ignored.
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    // First valid edge after release is processed normally.
    drive(1'b1, KAT_IN[1], KAT_OUT[1]);
    idle();

    // Random columns with random gaps.
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(3) == 0) idle();
      drive_ref(1'b1, d);
    end
    idle();
    repeat (3) @(negedge clk);

    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
